// File: rtl/md_scheduler_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operation codes,
// sequencer states, default latencies and the result pair type.
package md_scheduler_pkg;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Multi-cycle ops are the only ones that hold the pipeline.
  function automatic logic isLongOp(md_op_e op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: isLongOp = 1'b1;
      default:                            isLongOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// E-stage / hazard-side bundle of the multiply/divide sequencer.
interface md_scheduler_if;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_req;

  modport master (
    output start, md_op, rs_val, rt_val, d_is_md,
    input  busy, hi, lo, stall_req
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, d_is_md,
    output busy, hi, lo, stall_req
  );

endinterface

// File: rtl/md_scheduler_arith.sv
// Combinational 32x32 multiply and divide result generator, signed or unsigned,
// with a divide-by-zero flag. Division works on magnitudes so INT_MIN / -1 wraps cleanly.
module md_scheduler_arith
  import md_scheduler_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output hilo_t       mul_o,
  output hilo_t       div_o,
  output logic        divZero_o
);

  logic [63:0] aExt;
  logic [63:0] bExt;
  logic [63:0] prod;
  logic        aNeg;
  logic        bNeg;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [31:0] bSafe;
  logic [31:0] qMag;
  logic [31:0] rMag;

  always_comb begin
    aExt = signed_i ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    bExt = signed_i ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    prod = aExt * bExt;
    mul_o.hi = prod[63:32];
    mul_o.lo = prod[31:0];
  end

  // Quotient is negative when signs differ; remainder follows the dividend.
  always_comb begin
    aNeg      = signed_i & a_i[31];
    bNeg      = signed_i & b_i[31];
    aMag      = aNeg ? (32'd0 - a_i) : a_i;
    bMag      = bNeg ? (32'd0 - b_i) : b_i;
    divZero_o = (b_i == 32'd0);
    bSafe     = divZero_o ? 32'd1 : bMag;
    qMag      = aMag / bSafe;
    rMag      = aMag % bSafe;
    div_o.lo  = (aNeg ^ bNeg) ? (32'd0 - qMag) : qMag;
    div_o.hi  = aNeg ? (32'd0 - rMag) : rMag;
  end

endmodule

// File: rtl/md_scheduler.sv
// HI/LO owner beside the E-stage ALU: counts out multiply/divide latency,
// commits results to HI/LO and asks the hazard unit to stall dependent D-stage ops.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input logic           clk,
  input logic           reset,
  md_scheduler_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      opA_q;
  logic [31:0]      opB_q;
  logic             signed_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  md_op_e opIn;
  hilo_t  mulRes;
  hilo_t  divRes;
  logic   divZero;
  hilo_t  result_d;
  logic   writeRes_d;
  logic   busy;

  assign opIn = md_op_e'(bus.md_op);

  md_scheduler_arith u_arith (
    .a_i      (opA_q),
    .b_i      (opB_q),
    .signed_i (signed_q),
    .mul_o    (mulRes),
    .div_o    (divRes),
    .divZero_o(divZero)
  );

  // A zero divisor still burns the full latency but leaves HI/LO untouched.
  always_comb begin
    result_d   = (state_q == ST_DIV) ? divRes : mulRes;
    writeRes_d = (state_q == ST_MUL) | ((state_q == ST_DIV) & ~divZero);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      signed_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            case (opIn)
              MD_MULT, MD_MULTU: begin
                opA_q    <= bus.rs_val;
                opB_q    <= bus.rt_val;
                signed_q <= (opIn == MD_MULT);
                state_q  <= ST_MUL;
                cnt_q    <= CNT_W'(MUL_LAT);
              end
              MD_DIV, MD_DIVU: begin
                opA_q    <= bus.rs_val;
                opB_q    <= bus.rt_val;
                signed_q <= (opIn == MD_DIV);
                state_q  <= ST_DIV;
                cnt_q    <= CNT_W'(DIV_LAT);
              end
              MD_MTHI: hi_q <= bus.rs_val;
              MD_MTLO: lo_q <= bus.rs_val;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          // A start arriving here is a hazard-unit bug and is deliberately dropped.
          if (cnt_q == CNT_W'(1)) begin
            if (writeRes_d) begin
              hi_q <= result_d.hi;
              lo_q <= result_d.lo;
            end
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign bus.busy = busy;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // MTHI/MTLO in E never stall: their write lands before D reaches E.
  assign bus.stall_req = bus.d_is_md & (busy | (reset & bus.start & isLongOp(opIn)));

endmodule

// File: tb/tb_md_scheduler.sv
// Randomized scoreboard bench for md_scheduler: a queue of expected HI/LO results
// is popped by a monitor each time busy falls; stall_req is checked cycle by cycle.
module tb_md_scheduler;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  md_scheduler_if mdBus();

  md_scheduler #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mdBus.slave)
  );

  always #5 clk = ~clk;

  exp_t        sbQ[$];
  int          errors  = 0;
  int          checks  = 0;
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;
  bit          prevBusy = 1'b0;
  int          busyRun  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a busy falling edge is a completed operation; compare with the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      prevBusy = 1'b0;
      busyRun  = 0;
    end else begin
      if (mdBus.busy) begin
        busyRun++;
      end else if (prevBusy) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_completion: actual hi=%h lo=%h required no completion",
                   mdBus.hi, mdBus.lo);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sb_hi", mdBus.hi, e.hi);
          checkOutput("sb_lo", mdBus.lo, e.lo);
          checkOutput("sb_busy_cycles", 32'(busyRun), 32'(e.lat));
        end
        busyRun = 0;
      end
      prevBusy = mdBus.busy;
    end
  end

  // Busy period: random noise on the inputs must not disturb the running op.
  task automatic runBusy(input int lat);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      mdBus.start   = ($urandom_range(0, 3) == 0);
      mdBus.md_op   = 3'($urandom_range(0, 7));
      mdBus.rs_val  = $urandom;
      mdBus.rt_val  = $urandom;
      mdBus.d_is_md = 1'($urandom_range(0, 1));
      #1;
      checkOutput("busy_high", 32'(mdBus.busy), 32'd1);
      checkOutput("stall_busy", 32'(mdBus.stall_req), 32'(mdBus.d_is_md));
    end
    @(negedge clk);
    mdBus.start   = 1'b0;
    mdBus.d_is_md = 1'b1;
    #1;
    checkOutput("stall_after", 32'(mdBus.stall_req), 32'd0);
    checkOutput("pending", 32'(sbQ.size()), 32'd0);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                               input logic dIsMd, input bit waitDone);
    logic [31:0] eHi;
    logic [31:0] eLo;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    int          lat;
    bit          isLong;
    eHi    = modelHi;
    eLo    = modelLo;
    lat    = 0;
    isLong = (op >= 3'd1) && (op <= 3'd4);
    case (op)
      3'd1: begin
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        p  = 64'(sa * sb);
        {eHi, eLo} = p;
        lat = MUL_LAT;
      end
      3'd2: begin
        p = {32'd0, rs} * {32'd0, rt};
        {eHi, eLo} = p;
        lat = MUL_LAT;
      end
      3'd3: begin
        lat = DIV_LAT;
        if (rt != 32'd0) begin
          sa  = longint'($signed(rs));
          sb  = longint'($signed(rt));
          eLo = 32'(sa / sb);
          eHi = 32'(sa % sb);
        end
      end
      3'd4: begin
        lat = DIV_LAT;
        if (rt != 32'd0) begin
          eLo = rs / rt;
          eHi = rs % rt;
        end
      end
      3'd5: eHi = rs;
      3'd6: eLo = rs;
      default: ;
    endcase

    @(negedge clk);
    mdBus.start   = 1'b1;
    mdBus.md_op   = op;
    mdBus.rs_val  = rs;
    mdBus.rt_val  = rt;
    mdBus.d_is_md = dIsMd;
    #1;
    checkOutput("stall_at_start", 32'(mdBus.stall_req), 32'(dIsMd & isLong));
    if (isLong) sbQ.push_back('{hi: eHi, lo: eLo, lat: lat});
    modelHi = eHi;
    modelLo = eLo;
    @(posedge clk);
    if (waitDone) begin
      if (isLong) begin
        runBusy(lat);
      end else begin
        @(negedge clk);
        mdBus.start   = 1'b0;
        mdBus.d_is_md = 1'b0;
        #1;
        checkOutput("short_busy", 32'(mdBus.busy), 32'd0);
        checkOutput("short_hi", mdBus.hi, modelHi);
        checkOutput("short_lo", mdBus.lo, modelLo);
      end
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;

    mdBus.start   = 1'b1;
    mdBus.md_op   = 3'd1;
    mdBus.rs_val  = 32'd3;
    mdBus.rt_val  = 32'd4;
    mdBus.d_is_md = 1'b1;
    #12;
    checkOutput("reset_busy", 32'(mdBus.busy), 32'd0);
    checkOutput("reset_hi", mdBus.hi, 32'd0);
    checkOutput("reset_lo", mdBus.lo, 32'd0);
    checkOutput("reset_stall", 32'(mdBus.stall_req), 32'd0);
    @(negedge clk);
    #2;
    mdBus.start = 1'b0;
    reset       = 1'b1;

    applyStimulus(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
    checkOutput("mult_neg_hi", mdBus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_neg_lo", mdBus.lo, 32'hFFFF_FFF1);

    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    checkOutput("multu_hi", mdBus.hi, 32'h0000_0001);
    checkOutput("multu_lo", mdBus.lo, 32'hFFFF_FFFE);

    applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    checkOutput("div_neg_hi", mdBus.hi, 32'hFFFF_FFFF);
    checkOutput("div_neg_lo", mdBus.lo, 32'hFFFF_FFFD);

    applyStimulus(3'd4, 32'd7, 32'd2, 1'b0, 1'b1);
    checkOutput("divu_hi", mdBus.hi, 32'd1);
    checkOutput("divu_lo", mdBus.lo, 32'd3);

    applyStimulus(3'd5, 32'h0000_1234, 32'd0, 1'b1, 1'b1);
    applyStimulus(3'd6, 32'h0000_5678, 32'd0, 1'b1, 1'b1);
    applyStimulus(3'd3, 32'd99, 32'd0, 1'b1, 1'b1);
    checkOutput("divzero_hi", mdBus.hi, 32'h0000_1234);
    checkOutput("divzero_lo", mdBus.lo, 32'h0000_5678);

    applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    checkOutput("div_ovf_hi", mdBus.hi, 32'd0);
    checkOutput("div_ovf_lo", mdBus.lo, 32'h8000_0000);

    applyStimulus(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b1);
    applyStimulus(3'd0, 32'hCAFE_F00D, 32'd1, 1'b1, 1'b1);

    // Reset lands in the third busy cycle of a divide.
    applyStimulus(3'd3, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(mdBus.busy), 32'd0);
    checkOutput("midreset_hi", mdBus.hi, 32'd0);
    checkOutput("midreset_lo", mdBus.lo, 32'd0);
    checkOutput("midreset_stall", 32'(mdBus.stall_req), 32'd0);
    sbQ.delete();
    modelHi = 32'd0;
    modelLo = 32'd0;
    @(negedge clk);
    mdBus.start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;

    applyStimulus(3'd1, 32'd6, 32'd7, 1'b0, 1'b1);
    checkOutput("post_reset_hi", mdBus.hi, 32'd0);
    checkOutput("post_reset_lo", mdBus.lo, 32'd42);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rt = 32'd0;
        1:       rt = 32'hFFFF_FFFF;
        2:       rt = 32'($urandom_range(1, 15));
        default: rt = $urandom;
      endcase
      applyStimulus(op, rs, rt, 1'($urandom_range(0, 1)), 1'b1);
    end

    @(negedge clk);
    #1;
    checkOutput("queue_empty", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
